// File: rtl/priority_encoder_serializer_pkg.sv
// -----------------------------------------------------------------------------
// priority_pkg
// Shared definitions for the priority encoder/serializer and the decoder side:
// decode-mode constants, the encoder FSM state type, the mode-to-mask helper
// and a population-count helper.
// Helpers work on a MAX_WIDTH-bit vector; callers truncate/extend to WIDTH.
// -----------------------------------------------------------------------------
package priority_pkg;

    localparam int unsigned MAX_WIDTH = 64;

    localparam logic [1:0] MODE_2X4  = 2'b00;
    localparam logic [1:0] MODE_3X8  = 2'b01;
    localparam logic [1:0] MODE_4X16 = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef enum logic {
        IDLE,
        EMIT
    } enc_state_t;

    // Low 4 bits, low 8 bits, full width, or nothing for the reserved mode.
    function automatic logic [MAX_WIDTH-1:0] mode_mask(input logic [1:0] mode,
                                                       input int unsigned width);
        logic [MAX_WIDTH-1:0] m;
        m = '0;
        case (mode)
            MODE_2X4:  m = MAX_WIDTH'(16'h000F);
            MODE_3X8:  m = MAX_WIDTH'(16'h00FF);
            MODE_4X16: m = (width >= MAX_WIDTH) ? '1
                                                : ((MAX_WIDTH'(1) << width) - MAX_WIDTH'(1));
            default:   m = '0;
        endcase
        return m;
    endfunction

    function automatic logic [7:0] popcount(input logic [MAX_WIDTH-1:0] v);
        logic [MAX_WIDTH-1:0] t;
        logic [7:0]           cnt;
        t   = v;
        cnt = '0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            cnt = cnt + 8'(t[0]);
            t   = t >> 1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/priority_encoder_serializer_if.sv
// -----------------------------------------------------------------------------
// priority_encoder_serializer_if
// Request (in_*) and index (out_*) handshake bundle for the encoder/serializer.
//   slave  : block side  (in_valid/in_en_n/in_mode/in_vec/out_ready in;
//                          in_ready/out_valid/out_idx/out_last/out_count/busy out)
//   master : source/consumer side (mirror of slave)
// Macro PRIORITY_ENCODER_ZERO_REPORT_EN adds out_zero (block -> consumer).
// -----------------------------------------------------------------------------
interface priority_encoder_serializer_if #(
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned IDX_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic             in_en_n;
    logic [1:0]       in_mode;
    logic [WIDTH-1:0] in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic [IDX_W:0]   out_count;
    logic             busy;

`ifdef PRIORITY_ENCODER_ZERO_REPORT_EN
    logic             out_zero;

    modport slave (
        input  in_valid, in_en_n, in_mode, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_count, busy, out_zero
    );
    modport master (
        output in_valid, in_en_n, in_mode, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_count, busy, out_zero
    );
`else
    modport slave (
        input  in_valid, in_en_n, in_mode, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_count, busy
    );
    modport master (
        output in_valid, in_en_n, in_mode, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_count, busy
    );
`endif

endinterface

// File: rtl/priority_encoder_serializer_find_msb.sv
// -----------------------------------------------------------------------------
// priority_find_msb
// Combinational most-significant-set-bit finder.
//   vec : input vector
//   idx : index of the highest set bit (0 when vec is zero)
//   any : vec has at least one bit set
// -----------------------------------------------------------------------------
module priority_find_msb #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0]         vec,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     any
);
    localparam int unsigned IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] scan;

    // Ascending scan: the last hit wins, leaving the highest set index.
    always_comb begin
        idx  = '0;
        scan = vec;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (scan[0]) idx = IDX_W'(i);
            scan = scan >> 1;
        end
    end

    assign any = |vec;

endmodule

// File: rtl/priority_encoder_serializer.sv
// -----------------------------------------------------------------------------
// priority_encoder_serializer
// Accepts a multi-hot request vector, masks it to the selected decode width and
// emits the index of every set bit, highest first, one per output handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : priority_encoder_serializer_if.slave
//                in_valid/in_ready/in_en_n/in_mode/in_vec   request side
//                out_valid/out_ready/out_idx/out_last/out_count  index side
//                busy                                        state != IDLE
// Macro PRIORITY_ENCODER_ZERO_REPORT_EN: an accepted, enabled, empty vector
// yields one beat (idx 0, last 1, count 0) flagged on bus.out_zero.
// -----------------------------------------------------------------------------
module priority_encoder_serializer
    import priority_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    priority_encoder_serializer_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(WIDTH);

    enc_state_t           state, state_nxt;
    logic [WIDTH-1:0]     pending;
    logic [IDX_W:0]       count_q;
    logic [MAX_WIDTH-1:0] mask_full;
    logic [WIDTH-1:0]     masked;
    logic [IDX_W-1:0]     msb_idx;
    logic                 msb_any;
    logic                 accept;
    logic                 capture;
    logic                 beat;
    logic                 last;

    priority_find_msb #(.WIDTH(WIDTH)) u_find_msb (
        .vec (pending),
        .idx (msb_idx),
        .any (msb_any)
    );

    assign mask_full = mode_mask(bus.in_mode, WIDTH);
    assign masked    = bus.in_vec & mask_full[WIDTH-1:0];
    assign accept    = (state == IDLE) && bus.in_valid;
    assign beat      = (state == EMIT) && bus.out_ready;
    // An empty pending (zero-report beat) also counts as the final beat.
    assign last      = !msb_any || ((pending & (pending - WIDTH'(1))) == '0);

`ifdef PRIORITY_ENCODER_ZERO_REPORT_EN
    logic zero_q;
    assign capture      = accept && !bus.in_en_n;
    assign bus.out_zero = (state == EMIT) && zero_q;
`else
    assign capture      = accept && !bus.in_en_n && (masked != '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (capture)      state_nxt = EMIT;
            EMIT:    if (beat && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            count_q <= '0;
        end else if (capture) begin
            pending <= masked;
            count_q <= (IDX_W+1)'(popcount(MAX_WIDTH'(masked)));
        end else if (beat) begin
            pending <= pending & ~(WIDTH'(1) << msb_idx);
        end
    end

`ifdef PRIORITY_ENCODER_ZERO_REPORT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              zero_q <= 1'b0;
        else if (capture)        zero_q <= (masked == '0);
        else if (beat && last)   zero_q <= 1'b0;
    end
`endif

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == EMIT);
    assign bus.busy      = (state != IDLE);
    assign bus.out_idx   = msb_idx;
    assign bus.out_last  = (state == EMIT) && last;
    assign bus.out_count = count_q;

endmodule

// File: tb/tb_priority_encoder_serializer.sv
// -----------------------------------------------------------------------------
// tb_priority_encoder_serializer
// Self-checking bench for priority_encoder_serializer (WIDTH = 16). Expected
// beats come from a reference model that scans the masked vector from the top
// index down. Honours PRIORITY_ENCODER_ZERO_REPORT_EN when defined.
// -----------------------------------------------------------------------------
module tb_priority_encoder_serializer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    priority_encoder_serializer_if #(.WIDTH(16)) bus ();

    priority_encoder_serializer #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Captured handshaken beats.
    logic [3:0] cap_idx[$];
    logic       cap_last[$];
    logic [4:0] cap_count[$];
    logic       cap_zero[$];
    int         cap_cyc[$];

    // Reference model results.
    int   exp_idx[$];
    int   exp_count;
    logic exp_zero;

    function automatic int decode_width(input logic [1:0] mode);
        case (mode)
            2'b00:   return 4;
            2'b01:   return 8;
            2'b10:   return 16;
            default: return 0;
        endcase
    endfunction

    task automatic model(input logic [15:0] vec, input logic [1:0] mode, input logic en_n);
        int   w;
        logic [15:0] bit_m;
        exp_idx.delete();
        exp_count = 0;
        exp_zero  = 1'b0;
        if (en_n) return;
        w = decode_width(mode);
        for (int i = 15; i >= 0; i--) begin
            bit_m = 16'(1) << i;
            if (i < w && (vec & bit_m) != 16'h0) begin
                exp_idx.push_back(i);
                exp_count++;
            end
        end
`ifdef PRIORITY_ENCODER_ZERO_REPORT_EN
        if (exp_count == 0) begin
            exp_idx.push_back(0);
            exp_zero = 1'b1;
        end
`endif
    endtask

    // Waits (bounded) for in_ready, presents one vector for one cycle.
    task automatic apply_vec(input logic [15:0] vec, input logic [1:0] mode, input logic en_n);
        for (int c = 0; c < 60 && bus.in_ready !== 1'b1; c++) @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL in_ready_timeout: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_vec   = vec;
        bus.in_mode  = mode;
        bus.in_en_n  = en_n;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_vec   = $urandom;
        bus.in_mode  = 2'($urandom_range(0, 3));
        bus.in_en_n  = 1'($urandom_range(0, 1));
    endtask

    // Records beats until out_last is handshaken or the cycle budget expires.
    task automatic capture_beats(input int budget, input int stall_pct);
        logic done;
        done = 1'b0;
        cap_idx.delete(); cap_last.delete(); cap_count.delete();
        cap_zero.delete(); cap_cyc.delete();
        for (int c = 0; c < budget; c++) begin
            bus.out_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                cap_idx.push_back(bus.out_idx);
                cap_last.push_back(bus.out_last);
                cap_count.push_back(bus.out_count);
`ifdef PRIORITY_ENCODER_ZERO_REPORT_EN
                cap_zero.push_back(bus.out_zero);
`else
                cap_zero.push_back(1'b0);
`endif
                cap_cyc.push_back(c);
                done = bus.out_last;
            end
            @(negedge clk);
            if (done) break;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.out_idx !== 4'd0 || bus.out_last !== 1'b0 || bus.out_count !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_values: rdy=%b vld=%b busy=%b idx=%0d last=%b cnt=%0d required 1 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.out_idx, bus.out_last, bus.out_count);
        end
`ifdef PRIORITY_ENCODER_ZERO_REPORT_EN
        vectors++;
        if (bus.out_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_zero: out_zero=%b required 0", bus.out_zero);
        end
`endif
    endtask

    task automatic test_basic_burst;
        int exp[4] = '{15, 10, 5, 0};
        apply_vec(16'h8421, 2'b10, 1'b0);
        capture_beats(20, 0);
        vectors++;
        if (cap_idx.size() != 4) begin
            miscompares++;
            $display("FAIL basic_beats: got %0d beats required 4", cap_idx.size());
        end
        for (int i = 0; i < cap_idx.size() && i < 4; i++) begin
            vectors++;
            if (cap_idx[i] !== 4'(exp[i]) || cap_last[i] !== (i == 3) ||
                cap_count[i] !== 5'd4 || cap_cyc[i] != i) begin
                miscompares++;
                $display("FAIL basic_beat%0d: idx=%0d last=%b cnt=%0d cyc=%0d required %0d %b 4 %0d",
                         i, cap_idx[i], cap_last[i], cap_count[i], cap_cyc[i], exp[i], (i == 3), i);
            end
        end
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_ready_after: in_ready=%b busy=%b required 1 0", bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_mode_mask;
        apply_vec(16'hFFF5, 2'b00, 1'b0);
        capture_beats(20, 0);
        vectors++;
        if (cap_idx.size() != 2 || cap_idx[0] !== 4'd2 || cap_idx[1] !== 4'd0 ||
            cap_last[0] !== 1'b0 || cap_last[1] !== 1'b1 || cap_count[0] !== 5'd2) begin
            miscompares++;
            $display("FAIL mode00_beats: n=%0d required 2 beats idx 2,0 count 2", cap_idx.size());
        end
        apply_vec(16'hFFFF, 2'b11, 1'b0);
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mode11_idle: in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
        end
        capture_beats(4, 0);
        vectors++;
        if (cap_idx.size() != 0) begin
            miscompares++;
            $display("FAIL mode11_beats: got %0d beats required 0", cap_idx.size());
        end
    endtask

    task automatic test_disable;
        apply_vec(16'h00F0, 2'b10, 1'b1);
        capture_beats(4, 0);
        vectors++;
        if (cap_idx.size() != 0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL disable: beats=%0d busy=%b required 0 0", cap_idx.size(), bus.busy);
        end
    endtask

    task automatic test_backpressure;
        bus.out_ready = 1'b0;
        apply_vec(16'h0009, 2'b10, 1'b0);
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_idx !== 4'd3 || bus.out_last !== 1'b0 ||
                bus.out_count !== 5'd2 || bus.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold%0d: vld=%b idx=%0d last=%b cnt=%0d rdy=%b required 1 3 0 2 0",
                         c, bus.out_valid, bus.out_idx, bus.out_last, bus.out_count, bus.in_ready);
            end
            bus.in_valid = 1'b1;
            bus.in_vec   = 16'hFFFF;
            bus.in_mode  = 2'b10;
            bus.in_en_n  = 1'b0;
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        capture_beats(20, 0);
        vectors++;
        if (cap_idx.size() != 2 || cap_idx[0] !== 4'd3 || cap_last[0] !== 1'b0 ||
            cap_idx[1] !== 4'd0 || cap_last[1] !== 1'b1 || cap_count[1] !== 5'd2) begin
            miscompares++;
            $display("FAIL stall_release: n=%0d required 2 beats idx 3,0 last 0,1 count 2", cap_idx.size());
        end
        capture_beats(4, 0);
        vectors++;
        if (cap_idx.size() != 0) begin
            miscompares++;
            $display("FAIL stall_ignored_valid: got %0d extra beats required 0", cap_idx.size());
        end
    endtask

    task automatic test_reset_mid_burst;
        bus.out_ready = 1'b1;
        apply_vec(16'hF000, 2'b10, 1'b0);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_idx !== 4'd15) begin
            miscompares++;
            $display("FAIL midrst_first: vld=%b idx=%0d required 1 15", bus.out_valid, bus.out_idx);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 ||
            bus.out_idx !== 4'd0 || bus.out_last !== 1'b0 || bus.out_count !== 5'd0) begin
            miscompares++;
            $display("FAIL midrst_async: vld=%b rdy=%b busy=%b idx=%0d last=%b cnt=%0d required 0 1 0 0 0 0",
                     bus.out_valid, bus.in_ready, bus.busy, bus.out_idx, bus.out_last, bus.out_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        apply_vec(16'h0002, 2'b10, 1'b0);
        capture_beats(20, 0);
        vectors++;
        if (cap_idx.size() != 1 || cap_idx[0] !== 4'd1 || cap_last[0] !== 1'b1 || cap_count[0] !== 5'd1) begin
            miscompares++;
            $display("FAIL midrst_after: n=%0d required 1 beat idx 1 last 1 count 1", cap_idx.size());
        end
    endtask

    task automatic test_empty;
        apply_vec(16'hFF00, 2'b01, 1'b0);
        capture_beats(20, 0);
`ifdef PRIORITY_ENCODER_ZERO_REPORT_EN
        vectors++;
        if (cap_idx.size() != 1 || cap_idx[0] !== 4'd0 || cap_zero[0] !== 1'b1 ||
            cap_last[0] !== 1'b1 || cap_count[0] !== 5'd0) begin
            miscompares++;
            $display("FAIL empty_report: n=%0d required 1 beat idx 0 zero 1 last 1 count 0", cap_idx.size());
        end
`else
        vectors++;
        if (cap_idx.size() != 0) begin
            miscompares++;
            $display("FAIL empty_silent: got %0d beats required 0", cap_idx.size());
        end
`endif
    endtask

    task automatic test_random;
        logic [15:0] vec;
        logic [1:0]  mode;
        logic        en_n;
        for (int n = 0; n < 40; n++) begin
            vec  = 16'($urandom);
            mode = 2'($urandom_range(0, 3));
            en_n = ($urandom_range(0, 4) == 0);
            model(vec, mode, en_n);
            apply_vec(vec, mode, en_n);
            capture_beats((exp_idx.size() == 0) ? 4 : 300, 30);
            vectors++;
            if (cap_idx.size() != exp_idx.size()) begin
                miscompares++;
                $display("FAIL rand%0d_beats: vec=%h mode=%0d en_n=%b got %0d beats required %0d",
                         n, vec, mode, en_n, cap_idx.size(), exp_idx.size());
            end
            for (int i = 0; i < cap_idx.size() && i < exp_idx.size(); i++) begin
                vectors++;
                if (cap_idx[i] !== 4'(exp_idx[i]) || cap_last[i] !== (i == exp_idx.size() - 1) ||
                    cap_count[i] !== 5'(exp_count) || cap_zero[i] !== exp_zero) begin
                    miscompares++;
                    $display("FAIL rand%0d_beat%0d: idx=%0d last=%b cnt=%0d zero=%b required %0d %b %0d %b",
                             n, i, cap_idx[i], cap_last[i], cap_count[i], cap_zero[i],
                             exp_idx[i], (i == exp_idx.size() - 1), exp_count, exp_zero);
                end
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_en_n   = 1'b0;
        bus.in_mode   = 2'b00;
        bus.in_vec    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_basic_burst;
        test_mode_mask;
        test_disable;
        test_backpressure;
        test_reset_mid_burst;
        test_empty;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
